// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - shared types for the memory-stage data-port bridge
package dmem_bridge_pkg;

  typedef logic [31:0] word_t;

  localparam logic [1:0] MSIZE_B = 2'd0;
  localparam logic [1:0] MSIZE_H = 2'd1;
  localparam logic [1:0] MSIZE_W = 2'd2;

  typedef struct packed {
    logic       ren;
    word_t      addr;
    logic [1:0] size;
  } m_r_t;

  typedef struct packed {
    logic       wen;
    word_t      addr;
    word_t      wd;
    logic [1:0] size;
  } m_w_t;

  typedef enum logic [2:0] {
    DB_IDLE,
    DB_ADDR,
    DB_WAIT,
    DB_DONE,
    DB_DRAIN
  } dbridge_state_t;

  // One SRAM-like bus request as held across the address phase
  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    word_t      addr;
    word_t      wdata;
  } dreq_t;

endpackage

// File: rtl/dmem_bridge_if.sv
// rtl/dmem_bridge_if.sv - SRAM-like data bus between the bridge and the AXI wrapper
interface dmem_bridge_if;
  import dmem_bridge_pkg::*;

  logic       data_req;
  logic       data_wr;
  logic [1:0] data_size;
  word_t      data_addr;
  word_t      data_wdata;
  logic       data_addr_ok;
  logic       data_data_ok;
  word_t      data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );

endinterface

// File: rtl/dmem_bridge.sv
// rtl/dmem_bridge.sv - turns one M-stage load/store into a single SRAM-like bus transaction
module dmem_bridge
  import dmem_bridge_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  m_r_t                mread,
  input  m_w_t                mwrite,
  input  logic                mem_advance,
  input  logic                cancel,
  output word_t               rd,
  output logic                d_data_ok,
  dmem_bridge_if.master       dbus
);

  dbridge_state_t state, state_nxt;
  dreq_t          lat;
  dreq_t          cur;
  dreq_t          drv;
  word_t          rbuf;
  logic           cancel_seen, cancel_seen_nxt;
  logic           pend;
  logic           issue;
  logic           capture_rd;

  // Gating with resetn keeps data_req low the instant reset is asserted.
  always_comb begin
    pend      = resetn & (mread.ren | mwrite.wen) & ~cancel;
    cur.wr    = mwrite.wen;
    cur.size  = mwrite.wen ? mwrite.size : mread.size;
    cur.addr  = mwrite.wen ? mwrite.addr : mread.addr;
    cur.wdata = mwrite.wd;
  end

  always_comb begin
    state_nxt       = state;
    cancel_seen_nxt = cancel_seen;
    drv             = lat;
    dbus.data_req   = 1'b0;
    d_data_ok       = 1'b0;
    rd              = rbuf;
    issue           = 1'b0;
    capture_rd      = 1'b0;
    case (state)
      DB_IDLE: begin
        d_data_ok       = ~pend;
        cancel_seen_nxt = 1'b0;
        if (pend) begin
          issue         = 1'b1;
          dbus.data_req = 1'b1;
          drv           = cur;
          state_nxt     = dbus.data_addr_ok ? DB_WAIT : DB_ADDR;
        end
      end
      DB_ADDR: begin
        // The request cannot be withdrawn; a flush only decides whether the data is kept.
        dbus.data_req = 1'b1;
        if (cancel) cancel_seen_nxt = 1'b1;
        if (dbus.data_addr_ok) begin
          state_nxt       = (cancel | cancel_seen) ? DB_DRAIN : DB_WAIT;
          cancel_seen_nxt = 1'b0;
        end
      end
      DB_WAIT: begin
        if (dbus.data_data_ok) begin
          d_data_ok = 1'b1;
          rd        = dbus.data_rdata;
          if (cancel) begin
            state_nxt = DB_IDLE;
          end else begin
            capture_rd = ~lat.wr;
            state_nxt  = mem_advance ? DB_IDLE : DB_DONE;
          end
        end else if (cancel) begin
          state_nxt = DB_DRAIN;
        end
      end
      DB_DONE: begin
        d_data_ok = 1'b1;
        if (mem_advance | cancel) state_nxt = DB_IDLE;
      end
      DB_DRAIN: begin
        if (dbus.data_data_ok) state_nxt = DB_IDLE;
      end
      default: state_nxt = DB_IDLE;
    endcase
    dbus.data_wr    = drv.wr;
    dbus.data_size  = drv.size;
    dbus.data_addr  = drv.addr;
    dbus.data_wdata = drv.wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= DB_IDLE;
      cancel_seen <= 1'b0;
    end else begin
      state       <= state_nxt;
      cancel_seen <= cancel_seen_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat  <= '0;
      rbuf <= '0;
    end else begin
      if (issue)      lat  <= cur;
      if (capture_rd) rbuf <= dbus.data_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// tb/tb_dmem_bridge.sv - scoreboard bench: memory-stage driver, SRAM responder, reference memory
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    word_t      addr;
    word_t      wdata;
  } btx_t;

  logic  clk = 1'b0;
  logic  resetn = 1'b0;
  m_r_t  mread;
  m_w_t  mwrite;
  logic  mem_advance;
  logic  cancel;
  word_t rd;
  logic  d_data_ok;

  dmem_bridge_if bus ();

  dmem_bridge dut (
    .clk        (clk),
    .resetn     (resetn),
    .mread      (mread),
    .mwrite     (mwrite),
    .mem_advance(mem_advance),
    .cancel     (cancel),
    .rd         (rd),
    .d_data_ok  (d_data_ok),
    .dbus       (bus)
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_bad = 0;
  logic  aborted = 1'b0;
  word_t ref_mem [16];
  word_t bus_mem [16];
  btx_t  exp_bus_q [$];
  word_t exp_rd_q [$];
  int    acc_delay = 0;
  int    data_delay = 0;
  logic  outst = 1'b0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic word_t merge(input word_t old, input word_t wd,
                                  input logic [1:0] size, input logic [1:0] off);
    word_t m;
    case (size)
      MSIZE_B: m = 32'h0000_00FF << {off, 3'b000};
      MSIZE_H: m = 32'h0000_FFFF << {off, 3'b000};
      default: m = 32'hFFFF_FFFF;
    endcase
    return (old & ~m) | (wd & m);
  endfunction

  // SRAM-like responder: accepts after acc_delay request cycles, answers data_delay cycles later
  initial begin
    int    req_cyc;
    int    dcnt;
    logic  o_wr;
    word_t o_addr;
    req_cyc = 0;
    dcnt = 0;
    o_wr = 1'b0;
    o_addr = '0;
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata = '0;
    forever begin
      @(negedge clk);
      bus.data_addr_ok = !outst && (req_cyc >= acc_delay);
      bus.data_data_ok = outst && (dcnt == 0);
      bus.data_rdata   = (outst && !o_wr) ? bus_mem[o_addr[5:2]] : $urandom;
      #4;
      if (!resetn) begin
        outst = 1'b0;
        req_cyc = 0;
      end else if (outst) begin
        if (bus.data_data_ok) outst = 1'b0;
        else dcnt--;
      end else if (bus.data_req && bus.data_addr_ok) begin
        outst = 1'b1;
        dcnt = data_delay;
        req_cyc = 0;
        o_wr = bus.data_wr;
        o_addr = bus.data_addr;
        if (bus.data_wr)
          bus_mem[bus.data_addr[5:2]] = merge(bus_mem[bus.data_addr[5:2]], bus.data_wdata,
                                              bus.data_size, bus.data_addr[1:0]);
      end else if (bus.data_req) begin
        req_cyc++;
      end
    end
  end

  // Monitor: pops expected bus transactions on acceptance and load words when a load leaves M
  initial begin
    btx_t  e;
    word_t w;
    forever begin
      @(negedge clk);
      #3;
      if (resetn) begin
        if (bus.data_req) check("single_outstanding", 32'(outst), 32'd0);
        if (bus.data_req && bus.data_addr_ok) begin
          if (exp_bus_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL bus_unexpected: got request addr %h expected none", bus.data_addr);
          end else begin
            e = exp_bus_q.pop_front();
            check("bus_wr", 32'(bus.data_wr), 32'(e.wr));
            check("bus_size", 32'(bus.data_size), 32'(e.size));
            check("bus_addr", bus.data_addr, e.addr);
            if (e.wr) check("bus_wdata", bus.data_wdata, e.wdata);
          end
        end
        if (mread.ren && (cancel || (d_data_ok && mem_advance))) begin
          if (exp_rd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rd_unexpected: got load completion rd %h expected none", rd);
          end else begin
            w = exp_rd_q.pop_front();
            if (!cancel) check("load_rd", rd, w);
          end
        end
      end
    end
  end

  // op: 0 bubble, 1 load, 2 store. cancel_k is the M-cycle in which cancel is raised.
  task automatic run_instr(input int op, input word_t addr, input logic [1:0] size,
                           input word_t wd, input int cancel_k, input int stall_n,
                           output int len, output int reqs, output logic cxl);
    int   cyc;
    int   stall;
    logic leave;
    btx_t e;
    cyc = 0;
    stall = stall_n;
    leave = 1'b0;
    reqs = 0;
    cxl = 1'b0;
    // A request presented to an idle bridge is issued unless cancelled in its first cycle
    if (op != 0 && cancel_k != 0) begin
      e.wr = (op == 2);
      e.size = size;
      e.addr = addr;
      e.wdata = wd;
      exp_bus_q.push_back(e);
      if (op == 2) ref_mem[addr[5:2]] = merge(ref_mem[addr[5:2]], wd, size, addr[1:0]);
    end
    if (op == 1) exp_rd_q.push_back(ref_mem[addr[5:2]]);
    while (!leave) begin
      @(negedge clk);
      #1;
      mread.ren = (op == 1);
      mread.addr = addr;
      mread.size = size;
      mwrite.wen = (op == 2);
      mwrite.addr = addr;
      mwrite.wd = wd;
      mwrite.size = size;
      cancel = (cyc == cancel_k);
      #1;
      if (cyc == 0 && cancel_k == 0 && op != 0) begin
        check("idle_cancel_req", 32'(bus.data_req), 32'd0);
        check("idle_cancel_ok", 32'(d_data_ok), 32'd1);
      end
      if (bus.data_req) begin
        reqs++;
        check("req_addr", bus.data_addr, addr);
        check("req_wr", 32'(bus.data_wr), 32'(op == 2));
        check("req_size", 32'(bus.data_size), 32'(size));
      end
      mem_advance = d_data_ok && (stall == 0);
      if (d_data_ok && stall > 0) stall--;
      leave = cancel || mem_advance;
      cxl = cancel;
      cyc++;
      if (!leave && cyc > 60) begin
        n_cmp++;
        n_bad++;
        $display("FAIL instr_timeout: got no completion after %0d cycles expected completion", cyc);
        aborted = 1'b1;
        leave = 1'b1;
      end
    end
    len = cyc;
  endtask

  task automatic idle_inputs();
    mread = '0;
    mwrite = '0;
    cancel = 1'b0;
    mem_advance = 1'b0;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      idle_inputs();
      #1;
      n++;
    end while (!d_data_ok && n < 40);
    if (!d_data_ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got d_data_ok 0 expected 1 within 40 cycles");
      aborted = 1'b1;
    end
  endtask

  initial begin
    int         len;
    int         reqs;
    logic       cxl;
    int         op;
    int         w;
    logic [1:0] size;
    logic [1:0] off;
    word_t      addr;

    idle_inputs();
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bus_mem[i] = ref_mem[i];
    end
    ref_mem[1] = 32'hDEAD_BEEF;
    bus_mem[1] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    #2;
    check("rst_data_req", 32'(bus.data_req), 32'd0);
    check("rst_d_data_ok", 32'(d_data_ok), 32'd1);
    check("rst_rd", rd, 32'd0);
    check("rst_data_addr", bus.data_addr, 32'd0);
    check("rst_data_wr", 32'(bus.data_wr), 32'd0);
    check("rst_data_size", 32'(bus.data_size), 32'd0);
    check("rst_data_wdata", bus.data_wdata, 32'd0);
    @(negedge clk);
    #1;
    resetn = 1'b1;

    // Load accepted immediately, data next cycle, advancing at once
    acc_delay = 0;
    data_delay = 0;
    run_instr(1, 32'h1000_0004, MSIZE_W, 32'h0, 99, 0, len, reqs, cxl);
    check("imm_load_len", 32'(len), 32'd2);
    check("imm_load_reqs", 32'(reqs), 32'd1);

    // Byte store held in ADDR for three cycles before acceptance
    acc_delay = 3;
    run_instr(2, 32'h1000_0008, MSIZE_B, 32'h0000_00AB, 99, 0, len, reqs, cxl);
    check("slow_store_len", 32'(len), 32'd5);
    check("slow_store_reqs", 32'(reqs), 32'd4);

    // Load completing while the pipeline stalls two more cycles
    acc_delay = 0;
    run_instr(1, 32'h1000_0008, MSIZE_W, 32'h0, 99, 2, len, reqs, cxl);
    check("stall_load_len", 32'(len), 32'd4);
    check("stall_load_reqs", 32'(reqs), 32'd1);

    // Cancel in WAIT with the next load presented straight away during the drain
    data_delay = 2;
    run_instr(1, 32'h1000_000C, MSIZE_W, 32'h0, 1, 0, len, reqs, cxl);
    check("wait_cancel_len", 32'(len), 32'd2);
    data_delay = 0;
    run_instr(1, 32'h1000_0010, MSIZE_W, 32'h0, 99, 0, len, reqs, cxl);
    check("after_drain_len", 32'(len), 32'd4);
    check("after_drain_reqs", 32'(reqs), 32'd1);

    // Cancel arriving together with a load in IDLE
    run_instr(1, 32'h1000_0014, MSIZE_W, 32'h0, 0, 0, len, reqs, cxl);
    check("idle_cancel_len", 32'(len), 32'd1);
    drain_wait();

    for (int t = 0; t < 300 && !aborted; t++) begin
      op = int'($urandom_range(0, 2));
      w = int'($urandom_range(0, 15));
      size = 2'($urandom_range(0, 2));
      case (size)
        MSIZE_B: off = 2'($urandom_range(0, 3));
        MSIZE_H: off = {1'($urandom_range(0, 1)), 1'b0};
        default: off = 2'd0;
      endcase
      addr = 32'h1000_0000 | (32'(w) << 2) | 32'(off);
      acc_delay = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      data_delay = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      run_instr(op, addr, size, $urandom,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 99,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                len, reqs, cxl);
      if (cxl) drain_wait();
    end

    // Asynchronous reset while a load sits in ADDR
    if (!aborted) begin
      acc_delay = 10;
      @(negedge clk);
      #1;
      mread.ren = 1'b1;
      mread.addr = 32'h1000_0018;
      mread.size = MSIZE_W;
      cancel = 1'b0;
      mem_advance = 1'b0;
      @(negedge clk);
      #2;
      check("addr_state_req", 32'(bus.data_req), 32'd1);
      check("addr_state_ok", 32'(d_data_ok), 32'd0);
      resetn = 1'b0;
      #1;
      check("async_rst_req", 32'(bus.data_req), 32'd0);
      check("async_rst_rd", rd, 32'd0);
      idle_inputs();
      exp_bus_q.delete();
      exp_rd_q.delete();
      repeat (2) @(negedge clk);
      #1;
      resetn = 1'b1;
      #1;
      check("post_rst_req", 32'(bus.data_req), 32'd0);
      check("post_rst_ok", 32'(d_data_ok), 32'd1);
      acc_delay = 0;
      data_delay = 0;
      run_instr(1, 32'h1000_0004, MSIZE_W, 32'h0, 99, 0, len, reqs, cxl);
      check("post_rst_load_len", 32'(len), 32'd2);
    end

    @(negedge clk);
    #1;
    idle_inputs();
    repeat (2) @(negedge clk);
    #4;
    check("bus_queue_empty", 32'(exp_bus_q.size()), 32'd0);
    check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected end before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Responder end of the memory-stage data port. It accepts the `m_r_t`/`m_w_t` request driven by the memory stage and turns it into one transaction on the SRAM-like data bus to the AXI wrapper. It returns the load word on `rd` and reports `d_data_ok` to the hazard unit, which stalls the pipeline while `d_data_ok` is low. It sits between the memory stage and the top-level `data_*` bus, beside the instruction-side bridge.

## Interface
Parameters:
- none; widths come from `mips.svh` (`word_t` = 32 bits).

Ports:
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `mread`  in  `m_r_t`  load request from the memory stage.
  - `ren` = load valid.
  - `addr` = physical address.
  - `size`: 0 = byte, 1 = half, 2 = word.
- `mwrite`  in  `m_w_t`  store request from the memory stage.
  - `wen` = store valid.
  - `addr` = physical address.
  - `wd` = write data, already lane-aligned.
  - `size` = same encoding as `mread.size`.
- `mem_advance`  in  1  the memory-stage instruction leaves M this cycle, i.e. it is not stalled.
- `cancel`  in  1  exception flush of M; the current request is squashed.
- `rd`  out  `word_t`  load data to the memory stage.
- `d_data_ok`  out  1  the M-stage access is complete, or no access is pending.
- `data_req`  out  1  SRAM-like request.
- `data_wr`  out  1  1 = write, 0 = read.
- `data_size`  out  2  copied from the request `size`.
- `data_addr`  out  32  request address.
- `data_wdata`  out  32  write data.
- `data_addr_ok`  in  1  address accepted.
- `data_data_ok`  in  1  data phase done.
- `data_rdata`  in  32  read data.

## Operation
States, held in `dbridge_state_t`:
- **IDLE**
  - `pend = (mread.ren | mwrite.wen) & ~cancel`.
  - `data_req = pend`, combinational. Address and size come from the write fields if `wen`, otherwise from the read fields.
  - On issue, latch `{wr, size, addr, wdata}`.
  - If `pend & data_addr_ok`, go to WAIT. If `pend & ~data_addr_ok`, go to ADDR.
  - `d_data_ok = ~pend`.
- **ADDR**
  - `data_req = 1`, driven from the latched fields, until `data_addr_ok`.
  - A request is never withdrawn.
  - On `addr_ok`: go to DRAIN if `cancel` is seen in this state or was flagged earlier, else WAIT.
  - `d_data_ok = 0`.
- **WAIT**
  - `data_req = 0`.
  - On `data_data_ok`:
    - latch `data_rdata` into `rbuf` (reads only);
    - `d_data_ok = 1` and `rd = data_rdata`, both combinational;
    - go to IDLE if `mem_advance`, else DONE.
  - `cancel` without `data_ok`: go to DRAIN.
- **DONE**
  - `d_data_ok = 1`, `rd = rbuf`.
  - Go to IDLE on `mem_advance` or `cancel`.
  - No new request is issued in DONE.
- **DRAIN**
  - `data_req = 0`, `d_data_ok = 0`.
  - On `data_data_ok`, discard the data and go to IDLE.

Rules in every state:
- `rd = rbuf` whenever it is not driven directly from `data_rdata`.
- `rbuf` is unchanged by writes.
- `data_req` is never high outside IDLE/ADDR.
- At most one outstanding transaction.

## Timing
- **Reset values:**
  - state = IDLE;
  - latched fields = 0;
  - `rbuf` = 0;
  - `data_req`, `data_wr`, `data_size`, `data_addr`, `data_wdata`, `rd` = 0;
  - `d_data_ok` = 1 while no request is presented.
- **Best-case latency:** the request is accepted in cycle 0 and `data_ok` arrives in cycle 1, so `d_data_ok` rises in cycle 1.
- **Zero-bubble turnaround:** a WAIT→IDLE transition lets the next request issue in the following cycle.
- **Same-cycle events:**
  - `data_data_ok` and `cancel` in the same WAIT cycle: the data is discarded and the state goes to IDLE.
  - `cancel` and `mem_advance` in DONE: go to IDLE.
- **Reset mid-transaction:** the state returns to IDLE asynchronously. The bus side is reset together with the bridge, so no drain is required.

## Structure
- Add to `mips.svh`:
  - `dbridge_state_t` (IDLE, ADDR, WAIT, DONE, DRAIN);
  - size constants `MSIZE_B`/`MSIZE_H`/`MSIZE_W` = 0/1/2.
- Single module, no sub-module. The request latch and `rbuf` are plain registers alongside the state FSM.

## Test plan
- **Load with immediate accept:** `ren=1`, `addr=0x1000_0004`, `size=2`, `addr_ok=1` in cycle 0, `data_ok=1` with `rdata=0xDEADBEEF` in cycle 1, `mem_advance=1`. Required: `data_req`=1 only in cycle 0; `rd`=0xDEADBEEF and `d_data_ok`=1 in cycle 1; IDLE in cycle 2.
- **Store with delayed `addr_ok`:** `wen=1`, `wd=0x0000_00AB`, `size=0`, `addr_ok` after 3 cycles. Required: `data_req`, `data_wr`=1 and `data_size`=0 held for 4 cycles with stable fields; `d_data_ok`=0 until `data_ok`.
- **Completion while stalled:** `data_ok` arrives with `mem_advance=0` for 2 cycles. Required: the state goes to DONE; `rd` holds the read value and `d_data_ok`=1; no second `data_req` is issued.
- **Cancel in WAIT:** `cancel` in WAIT and a new load presented; `data_ok` arrives 2 cycles later. Required: `d_data_ok`=0 and `data_req`=0 until `data_ok`; the new request is issued in the following cycle.
- **Cancel in IDLE:** `cancel=1` with `ren=1`. Required: `data_req`=0 and `d_data_ok`=1.
- **Async reset in ADDR:** assert `resetn`=0 while in ADDR. Required: `data_req`=0 immediately and the state is IDLE.
